// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler: gathers LSB-first valid bits into a WIDTH-bit word and
// hands it downstream over a valid/ready output register. Optional parity: WORD_PARITY_EN.
module serial_word_assembler #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_i,
  input  logic             bit_valid_i,
  output logic [WIDTH-1:0] word_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic [4:0]       bit_cnt_o,
  output logic             ovf_o
`ifdef WORD_PARITY_EN
  ,
  output logic             parity_o
`endif
);

  typedef enum logic [0:0] {StFill, StHold} state_e;

  localparam logic [4:0] LastIdx = 5'(WIDTH - 1);
  // At WIDTH=32 a full shift register wraps the 5-bit count to 0.
  localparam logic [4:0] FullCnt = 5'(WIDTH);

  state_e           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_or;
  logic             r_valid;
  logic             r_ovf;

  logic [WIDTH-1:0] w_bit_mask;
  logic [WIDTH-1:0] w_sr_upd;
  logic             w_consume;
  logic             w_or_free;
  logic             w_last_bit;

  always_comb begin
    w_bit_mask = WIDTH'(1) << r_cnt;
    w_sr_upd   = bit_i ? (r_sr | w_bit_mask) : r_sr;
    w_consume  = r_valid & word_ready_i;
    w_or_free  = ~r_valid | word_ready_i;
    w_last_bit = (r_cnt == LastIdx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StFill;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_or    <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      // A consumed word drops valid unless a new word loads at the same edge.
      if (w_consume) begin
        r_valid <= 1'b0;
      end
      unique case (r_state)
        StFill: begin
          if (bit_valid_i) begin
            if (!w_last_bit) begin
              r_sr  <= w_sr_upd;
              r_cnt <= r_cnt + 5'd1;
            end else if (w_or_free) begin
              r_or    <= w_sr_upd;
              r_valid <= 1'b1;
              r_sr    <= '0;
              r_cnt   <= '0;
            end else begin
              r_sr    <= w_sr_upd;
              r_cnt   <= FullCnt;
              r_state <= StHold;
            end
          end
        end
        StHold: begin
          if (bit_valid_i) begin
            r_ovf <= 1'b1;
          end
          if (w_consume) begin
            r_or    <= r_sr;
            r_valid <= 1'b1;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_state <= StFill;
          end
        end
        default: r_state <= StFill;
      endcase
    end
  end

`ifdef WORD_PARITY_EN
  logic r_parity;

  // Tracks r_or: updated on exactly the edges that load a new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (r_state == StFill && bit_valid_i && w_last_bit && w_or_free) begin
      r_parity <= ^w_sr_upd;
    end else if (r_state == StHold && w_consume) begin
      r_parity <= ^r_sr;
    end
  end

  assign parity_o = r_parity;
`endif

  assign word_o       = r_or;
  assign word_valid_o = r_valid;
  assign bit_cnt_o    = r_cnt;
  assign ovf_o        = r_ovf;

endmodule

// File: doc/serial_word_assembler.md
SERIAL_WORD_ASSEMBLER -- requirements
Module: serial_word_assembler

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the assembled word width in bits (legal range 4..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port bit_i, input, 1 bit: serial data bit.
REQ-005 SHALL have port bit_valid_i, input, 1 bit: bit_i is sampled only in cycles where this is 1.
REQ-006 SHALL have port word_o, output, WIDTH bits: assembled word presented to the downstream pattern detector.
REQ-007 SHALL have port word_valid_o, output, 1 bit: word_o holds an unconsumed word.
REQ-008 SHALL have port word_ready_i, input, 1 bit: downstream accepts word_o in cycles where word_valid_o and word_ready_i are both 1.
REQ-009 SHALL have port bit_cnt_o, output, 5 bits: number of bits currently held in the shift register.
REQ-010 SHALL have port ovf_o, output, 1 bit: sticky flag, set when a valid bit was dropped.

Function
REQ-011 SHALL contain a WIDTH-bit shift register (SR), a 5-bit bit counter (CNT), a WIDTH-bit output register (OR) with its valid flag, and a 2-state FSM: FILL and HOLD.
REQ-012 SHALL place bits LSB-first: the first valid bit of a word lands in word_o[0] and the WIDTH-th lands in word_o[WIDTH-1].
REQ-013 In FILL with bit_valid_i=1 and CNT<WIDTH-1: SR[CNT] SHALL take bit_i and CNT SHALL increment by 1.
REQ-014 In FILL with bit_valid_i=1 and CNT=WIDTH-1 (completing bit), when OR is empty or consumed in the same cycle, the completed word (including bit_i) SHALL load into OR, word_valid_o SHALL be 1 from the next cycle, CNT SHALL be 0, and SR SHALL clear.
REQ-015 Latency SHALL be 1 cycle: the word is visible on word_o in the cycle after the completing bit is sampled.
REQ-016 In REQ-014 when OR is full and not consumed that cycle, the completed word SHALL stay in SR, CNT SHALL equal WIDTH, and the FSM SHALL enter HOLD.
REQ-017 In HOLD, when OR is consumed, SR SHALL transfer to OR at that edge, word_valid_o SHALL remain 1, SR and CNT SHALL clear, and the FSM SHALL return to FILL.
REQ-018 In HOLD (including the transfer cycle), any bit with bit_valid_i=1 SHALL be dropped and ovf_o SHALL be set to 1.
REQ-019 ovf_o SHALL stay 1 until reset.
REQ-020 With word_valid_o=1 and word_ready_i=1 and no new word loading, word_valid_o SHALL clear at that edge.
REQ-021 word_o SHALL stay stable while word_valid_o=1 and word_ready_i=0.
REQ-022 bit_valid_i=0 SHALL leave SR and CNT unchanged, so gaps between bits of any length are allowed.
REQ-023 word_ready_i while word_valid_o=0 SHALL have no effect.

Reset
REQ-024 rst=1 at a clock edge SHALL set FSM=FILL, SR=0, CNT=0, OR=0, word_valid_o=0, bit_cnt_o=0 and ovf_o=0, discarding any partial or held word, and SHALL take priority over every other input.
REQ-025 The first valid bit after rst deasserts SHALL be placed at word_o[0].

Configuration
REQ-026 With macro WORD_PARITY_EN defined, SHALL add output parity_o (1 bit), registered alongside OR, equal to the XOR of the word in OR; reset value 0.
REQ-027 Without WORD_PARITY_EN, parity_o and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 Bench SHALL cover: reset; word_ready_i=1; 16 consecutive valid bits 1,0,1,0,0,... (rest 0) -> word_o=16'h0005 and word_valid_o=1 in the cycle after the 16th bit; parity_o=0 if enabled.
REQ-029 Bench SHALL cover: 16 valid bits interleaved with random bit_valid_i=0 gaps, pattern 16'hA5C3 LSB-first -> word_o=16'hA5C3; bit_cnt_o traces 0..15 then returns to 0.
REQ-030 Bench SHALL cover: word_ready_i=0; send 32 valid bits -> first word stays on word_o and stable, FSM enters HOLD, bit_cnt_o=16; a 33rd bit -> ovf_o=1; then word_ready_i=1 for one cycle -> second word appears with word_valid_o held at 1.
REQ-031 Bench SHALL cover: completing bit sampled in the same cycle as word_valid_o & word_ready_i -> new word loads with no bubble and no overflow.
REQ-032 Bench SHALL cover: rst asserted after 9 bits, and separately during HOLD -> all outputs 0 next cycle; the next 16 bits form a clean word.
